// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port SRAM arbiter serving instruction-fetch and data ports
module mem_arbiter #(
    parameter int ADDR_WIDTH    = 32,
    parameter int MEM_LATENCY   = 1,
    parameter int DATA_PRIORITY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  imem_read,
    input  logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_rdata,
    output logic                  imem_done,
    input  logic                  dmem_read,
    input  logic                  dmem_write,
    input  logic [1:0]            dmem_size,
    input  logic [ADDR_WIDTH-1:0] dmem_addr,
    input  logic [31:0]           dmem_wdata,
    output logic [31:0]           dmem_rdata,
    output logic                  dmem_done,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [1:0]            mem_size,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;
    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    logic [1:0]            state_q, state_d;
    logic                  gnt_dmem_q, gnt_dmem_d;
    logic                  last_dmem_q, last_dmem_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            size_q, size_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [31:0]           irdata_q, irdata_d;
    logic [31:0]           drdata_q, drdata_d;
    logic                  dreq, any_req, pick_dmem, enter_resp, issue;

    assign dreq    = dmem_read | dmem_write;
    assign any_req = dreq | imem_read;

    always_comb begin
        if (dreq && imem_read) begin
            pick_dmem = (DATA_PRIORITY != 0) ? 1'b1 : ~last_dmem_q;
        end else begin
            pick_dmem = dreq;
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_dmem_d  = gnt_dmem_q;
        last_dmem_d = last_dmem_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        size_d      = size_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        enter_resp  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    gnt_dmem_d  = pick_dmem;
                    last_dmem_d = pick_dmem;
                    // Fetches are normalised here so the issue cycle just replays the latch
                    if (pick_dmem) begin
                        wr_d    = dmem_write;
                        addr_d  = dmem_addr;
                        size_d  = dmem_size;
                        wdata_d = dmem_wdata;
                    end else begin
                        wr_d    = 1'b0;
                        addr_d  = imem_addr;
                        size_d  = 2'd2;
                        wdata_d = 32'd0;
                    end
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d = CW'(MEM_LATENCY - 1);
                if (MEM_LATENCY == 1) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        irdata_d = irdata_q;
        drdata_d = drdata_q;
        if (enter_resp && !wr_q) begin
            if (gnt_dmem_q) drdata_d = mem_rdata;
            else            irdata_d = mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            gnt_dmem_q  <= 1'b0;
            last_dmem_q <= 1'b1;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            size_q      <= 2'd0;
            wdata_q     <= 32'd0;
            cnt_q       <= '0;
            irdata_q    <= 32'd0;
            drdata_q    <= 32'd0;
        end else begin
            state_q     <= state_d;
            gnt_dmem_q  <= gnt_dmem_d;
            last_dmem_q <= last_dmem_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            irdata_q    <= irdata_d;
            drdata_q    <= drdata_d;
        end
    end

    assign issue      = (state_q == S_ISSUE);
    assign mem_read   = issue & ~wr_q;
    assign mem_write  = issue & wr_q;
    assign mem_size   = issue ? size_q : 2'd0;
    assign mem_addr   = issue ? addr_q : '0;
    assign mem_wdata  = issue ? wdata_q : 32'd0;
    assign imem_done  = (state_q == S_RESP) & ~gnt_dmem_q;
    assign dmem_done  = (state_q == S_RESP) & gnt_dmem_q;
    assign imem_rdata = irdata_q;
    assign dmem_rdata = drdata_q;
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port synchronous SRAM between the core's instruction-fetch port (imem) and data port (dmem).
- Sits between the multicycle core and the memory in the FPGA top level, replacing the dual-port connection.
- Serialises accesses, drives the SRAM strobes for exactly one issue cycle, and waits the SRAM's fixed read latency.
- Returns registered read data and a one-cycle done pulse to the granted requester.

Parameters:
- ADDR_WIDTH, 32, width of all address ports.
- MEM_LATENCY, 1, cycles from the issue cycle to valid mem_rdata (legal range ≥1).
- DATA_PRIORITY, 1, 1 = dmem wins simultaneous requests; 0 = round-robin on conflict.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_read  in  1  fetch request, held until imem_done.
- imem_addr  in  ADDR_WIDTH  fetch address.
- imem_rdata  out  32  registered fetch data.
- imem_done  out  1  one-cycle completion pulse.
- dmem_read  in  1  data read request.
- dmem_write  in  1  data write request.
- dmem_size  in  2  0 = byte, 1 = half, 2 = word; passed through to the SRAM.
- dmem_addr  in  ADDR_WIDTH  data address.
- dmem_wdata  in  32  write data.
- dmem_rdata  out  32  registered load data.
- dmem_done  out  1  one-cycle completion pulse.
- mem_read  out  1  SRAM read strobe.
- mem_write  out  1  SRAM write strobe.
- mem_size  out  2  SRAM access size.
- mem_addr  out  ADDR_WIDTH  SRAM address.
- mem_wdata  out  32  SRAM write data.
- mem_rdata  in  32  SRAM read data, valid MEM_LATENCY cycles after issue.

Behaviour:
- Reset, asserted asynchronously: state=IDLE; all outputs 0; imem_rdata and dmem_rdata = 0; latency counter = 0; last_grant = DMEM.
- Reset mid-transaction abandons the access. No done pulse is produced. The requester re-requests after reset.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: sample requests.
  - No request: stay in IDLE.
  - Any request: latch grant, address, size, wdata, and op (write if dmem_write, else read), then go to ISSUE.
  - dmem_read and dmem_write both high: treated as a write.
- Arbitration:
  - Only one requester active: it is granted.
  - Both active with DATA_PRIORITY=1: grant dmem.
  - Both active with DATA_PRIORITY=0: grant the port opposite last_grant. last_grant updates on every grant.
- ISSUE (exactly 1 cycle):
  - mem_read or mem_write=1; mem_addr, mem_size and mem_wdata driven from the latched values.
  - imem accesses force mem_size=2 and mem_wdata=0.
  - Load counter = MEM_LATENCY-1, then go to WAIT, or to RESP directly when MEM_LATENCY=1.
- WAIT: counter decrements each cycle; at 0 go to RESP.
- Capture: on the edge entering RESP, mem_rdata is captured into the granted port's rdata register (reads only).
  - Writes leave dmem_rdata unchanged.
  - The non-granted port's rdata never changes.
- RESP (1 cycle): granted port's done=1, then go to IDLE. Requests are ignored during RESP.
- Latency: request first seen in IDLE at cycle N → issue at N+1 → done at N+1+MEM_LATENCY. For MEM_LATENCY=1, done at N+2.
- Outside ISSUE: mem_read, mem_write, mem_size, mem_addr and mem_wdata = 0.
- Requester obligations:
  - Hold request and operands stable until done.
  - Deassert in the cycle after done unless issuing a new access.
  - A request still high in IDLE after done is treated as a new access.
- Back-to-back throughput: one access per 2+MEM_LATENCY cycles, including the IDLE sample cycle.
- Request dropped while pending: the access already latched completes and pulses done regardless. Inputs are not re-sampled.
- done is never asserted on both ports in the same cycle.

Test Plan:
- Lone fetch: imem_read=1, imem_addr=0x100, SRAM returns 0x00000013 → mem_read pulses for one cycle with mem_addr=0x100 and mem_size=2; imem_done=1 two cycles after the request; imem_rdata=0x00000013; dmem outputs unchanged.
- Lone store: dmem_write=1, addr=0x2004, size=0, wdata=0xAB → one-cycle mem_write with those values; dmem_done pulses; dmem_rdata keeps its previous value.
- Conflict with DATA_PRIORITY=1: imem and dmem requests in the same cycle → dmem served first with dmem_done; imem served in the next transaction; imem_done arrives three cycles after dmem_done.
- Conflict with DATA_PRIORITY=0: four consecutive simultaneous-request rounds → grant order imem, dmem, imem, dmem.
- MEM_LATENCY=3: fetch at cycle N → mem_read at N+1; capture of mem_rdata (0xDEADBEEF) at N+4; imem_done=1 at N+4; no strobes during N+2..N+4.
- Reset in WAIT: rst_n low mid-access → all outputs 0 immediately, asynchronously; no done pulse after release; a fresh request completes normally.
